reg_writeback: RTL
==================

# reg_writeback

Write-port sequencer for the LC-3 register file. Accepts register writeback requests from the execute/memory stages over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Replays each request onto the register file's DR/data/ld_reg write port as a three-cycle setup/strobe/hold sequence, and maintains the NZP condition codes. Also exports a per-register pending-write mask so decode can detect read-after-write hazards on SR1/SR2.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  writeback request present.
- wb_ready  out  1  FIFO can accept; equals (fifo_count != DEPTH), combinational from registered state.
- wb_dr  in  3  destination register of the request.
- wb_data  in  16  value to write.
- wb_setcc  in  1  request updates NZP when committed.
- DR  out  3  register-file write address; registered.
- data  out  16  register-file write data; registered.
- ld_reg  out  1  register-file write strobe; registered, one-cycle pulse.
- N, Z, P  out  1 each  condition codes; registered.
- busy_mask  out  8  bit r = 1 while any FIFO entry or the in-flight write targets register r.
- idle  out  1  FIFO empty and FSM in IDLE.

## Operation
- Reset is asynchronous, with these values:
  - DR=0, data=0, ld_reg=0.
  - N=0, Z=1, P=0.
  - FIFO emptied; FSM in IDLE.
  - busy_mask=0, idle=1, wb_ready=1.
- Enqueue: a request is accepted on any rising edge where wb_valid && wb_ready. The entry {dr, data, setcc} is pushed to the tail.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP when the FIFO is non-empty. The head is popped, and its dr/data are loaded into DR/data and its setcc into an in-flight flag.
  - SETUP -> STROBE unconditionally. In STROBE, ld_reg=1.
  - STROBE -> HOLD unconditionally. In HOLD, ld_reg=0.
  - HOLD -> SETUP if the FIFO is non-empty (pop as above); otherwise HOLD -> IDLE.
- DR and data are stable from SETUP through HOLD inclusive. They keep their last value in IDLE.
- ld_reg is high only in STROBE, so exactly one rising edge of ld_reg occurs per committed request.
- Condition codes are updated on the STROBE->HOLD edge, and only if the in-flight setcc=1:
  - N = data[15].
  - Z = (data == 0).
  - P = !N && !Z.
  - Exactly one of N/Z/P is high at all times.
- busy_mask is the OR of one-hot(dr) over valid FIFO entries, plus one-hot(DR) while the FSM is not in IDLE. It is combinational from registered state.
- Multiple pending writes to the same register commit in FIFO order. The bit stays set until the last one leaves HOLD.
- Total capacity is DEPTH queued plus 1 in flight. wb_ready depends only on the FIFO count.
- Simultaneous push and pop in one cycle is legal when the FIFO is full: the count stays at DEPTH, and the pop makes no space visible until the next cycle. No data is lost or duplicated.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- A request with wb_valid while wb_ready=0 is not accepted. The source must hold the request.
- Reset asserted mid-sequence:
  - ld_reg drops immediately.
  - Queued and in-flight writes are discarded.
  - NZP returns to 0/1/0.

## Timing
- Empty and idle, request accepted at edge t:
  - SETUP during cycle t..t+1.
  - ld_reg high between edges t+1 and t+2.
  - HOLD between edges t+2 and t+3.
  - NZP valid after edge t+2.
- busy_mask bit set visible after edge t. Cleared after edge t+3 if no further writes are pending to that register.
- Throughput: one commit per 3 cycles. Back-to-back sequences are HOLD -> SETUP with no IDLE gap.
- ld_reg never stays high for two consecutive cycles. Consecutive strobes are separated by at least 2 low cycles.
- idle rises the cycle after the final HOLD.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 mid-STROBE with 3 entries queued.
  - Required: ld_reg=0 immediately. After release, N/Z/P=0/1/0, busy_mask=0, idle=1, and no further ld_reg pulses occur.
- Single write:
  - Stimulus: push dr=3, data=16'h8001, setcc=1 while idle.
  - Required: DR=3 and data=8001 from t+1. ld_reg high exactly one cycle at t+1..t+2. N=1, Z=0, P=0 after t+2. busy_mask=8'h08 until t+3, then 8'h00.
- Condition-code gating:
  - Stimulus: push r1=0 with setcc=1, then r2=5 with setcc=0, then r4=7 with setcc=1.
  - Required: NZP reads Z, then stays Z, then P. ld_reg pulses for DR 1, 2, 4 in order.
- Full FIFO (DEPTH=4):
  - Stimulus: hold wb_valid with 6 distinct requests.
  - Required: wb_ready drops once 4 entries are queued plus 1 in flight. All 6 commit in order with correct data. Strobes are spaced exactly 3 cycles apart.
- Same-register hazard:
  - Stimulus: push r6=1 then r6=2 back-to-back.
  - Required: busy_mask[6] stays 1 continuously until HOLD of the second write ends. The final DR=6 strobe carries data=2.
- Full with simultaneous pop:
  - Stimulus: keep the FIFO full and offer wb_valid on the HOLD->SETUP pop edge.
  - Required: the request is not accepted that edge (wb_ready=0). It is accepted the next edge. No loss or duplication.

Source files
------------

// File: rtl/reg_writeback_if.sv
// Writeback request channel from the execute/memory stages into the register-file write sequencer.
interface reg_writeback_if;
    logic        valid;
    logic        ready;
    logic [2:0]  dr;
    logic [15:0] data;
    logic        setcc;

    modport master (output valid, output dr, output data, output setcc, input ready);
    modport slave  (input valid, input dr, input data, input setcc, output ready);
endinterface

// File: rtl/reg_writeback.sv
// LC-3 register-file write sequencer: buffers writeback requests and replays each as a
// setup/strobe/hold sequence on DR/data/ld_reg, tracking NZP and per-register pending writes.
module reg_writeback #(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    reg_writeback_if.slave  wb,
    output logic [2:0]      DR,
    output logic [15:0]     data,
    output logic            ld_reg,
    output logic            N,
    output logic            Z,
    output logic            P,
    output logic [7:0]      busy_mask,
    output logic            idle
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e          state_q;
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q;
    logic [2:0]      fifo_dr_q    [DEPTH];
    logic [15:0]     fifo_data_q  [DEPTH];
    logic            fifo_setcc_q [DEPTH];
    logic [2:0]      dr_q;
    logic [15:0]     data_q;
    logic            setcc_q;
    logic            ld_reg_q;
    logic            n_q, z_q, p_q;

    logic push, pop, bypass, enq;

    assign wb.ready = (count_q != FullCount);
    assign push     = wb.valid && wb.ready;
    assign pop      = ((state_q == StIdle) || (state_q == StHold)) && (count_q != '0);
    // An idle sequencer with nothing queued starts the incoming request directly.
    assign bypass   = (state_q == StIdle) && (count_q == '0) && push;
    assign enq      = push && !bypass;

    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_dr_q[wr_ptr_q]    <= wb.dr;
            fifo_data_q[wr_ptr_q]  <= wb.data;
            fifo_setcc_q[wr_ptr_q] <= wb.setcc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            dr_q     <= '0;
            data_q   <= '0;
            setcc_q  <= 1'b0;
            ld_reg_q <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b1;
            p_q      <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PtrW + 1)'(enq) - (PtrW + 1)'(pop);

            unique case (state_q)
                StIdle, StHold: begin
                    if (pop) begin
                        dr_q    <= fifo_dr_q[rd_ptr_q];
                        data_q  <= fifo_data_q[rd_ptr_q];
                        setcc_q <= fifo_setcc_q[rd_ptr_q];
                        state_q <= StSetup;
                    end else if (bypass) begin
                        dr_q    <= wb.dr;
                        data_q  <= wb.data;
                        setcc_q <= wb.setcc;
                        state_q <= StSetup;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    ld_reg_q <= 1'b1;
                    state_q  <= StStrobe;
                end
                StStrobe: begin
                    ld_reg_q <= 1'b0;
                    state_q  <= StHold;
                    if (setcc_q) begin
                        n_q <= data_q[15];
                        z_q <= (data_q == 16'h0000);
                        p_q <= !data_q[15] && (data_q != 16'h0000);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy_mask = 8'h00;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((PtrW + 1)'(i) < count_q) begin
                busy_mask[fifo_dr_q[rd_ptr_q + PtrW'(i)]] = 1'b1;
            end
        end
        if (state_q != StIdle) busy_mask[dr_q] = 1'b1;
    end

    assign DR     = dr_q;
    assign data   = data_q;
    assign ld_reg = ld_reg_q;
    assign N      = n_q;
    assign Z      = z_q;
    assign P      = p_q;
    assign idle   = (count_q == '0) && (state_q == StIdle);

endmodule
